// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             stall_out;

    modport master (
        output start, flush, funct3, operand1, operand2,
        input  result, done, busy, stall_out
    );

    modport slave (
        input  start, flush, funct3, operand1, operand2,
        output result, done, busy, stall_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per clock, holding the front of the pipeline while it works.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave mdu
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             sgn1_s, sgn2_s, neg1_s, neg2_s;
    logic             div_zero_s, div_ovf_s;
    logic [WIDTH-1:0] abs1_s, abs2_s, special_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s, step_hi_s, step_lo_s, fin_s;
    logic [2*WIDTH-1:0] prod_s;

    // Issue-time operand decode: signedness, magnitudes and the one-cycle divide cases.
    always_comb begin
        sgn1_s = (mdu.funct3 == 3'd1) || (mdu.funct3 == 3'd2) ||
                 (mdu.funct3 == 3'd4) || (mdu.funct3 == 3'd6);
        sgn2_s = (mdu.funct3 == 3'd1) || (mdu.funct3 == 3'd4) || (mdu.funct3 == 3'd6);
        neg1_s = sgn1_s & mdu.operand1[WIDTH-1];
        neg2_s = sgn2_s & mdu.operand2[WIDTH-1];
        abs1_s = neg_w(neg1_s, mdu.operand1);
        abs2_s = neg_w(neg2_s, mdu.operand2);
        div_zero_s = mdu.funct3[2] && (mdu.operand2 == {WIDTH{1'b0}});
        div_ovf_s  = ((mdu.funct3 == 3'd4) || (mdu.funct3 == 3'd6)) &&
                     (mdu.operand1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (mdu.operand2 == {WIDTH{1'b1}});
        if (div_zero_s) begin
            special_s = mdu.funct3[1] ? mdu.operand1 : {WIDTH{1'b1}};
        end else begin
            special_s = mdu.funct3[1] ? {WIDTH{1'b0}} : mdu.operand1;
        end
    end

    // One iteration of either algorithm; hi/lo are shared between product and remainder/quotient.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_q, lo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_q});
        div_diff_s  = div_shift_s[WIDTH-1:0] - b_q;
        if (op_q[2]) begin
            step_hi_s = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            step_lo_s = {lo_q[WIDTH-2:0], div_ge_s};
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        end
        prod_s = neg_2w(neg_q, {step_hi_s, step_lo_s});
        if (!op_q[2]) begin
            fin_s = (op_q == 3'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end else if (op_q[1]) begin
            fin_s = neg_w(neg_q, step_hi_s);
        end else begin
            fin_s = neg_w(neg_q, step_lo_s);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    op_d    = mdu.funct3;
                    neg_d   = (mdu.funct3 == 3'd6) ? neg1_s : (neg1_s ^ neg2_s);
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = abs1_s;
                    b_d     = abs2_s;
                    count_d = {CW{1'b0}};
                    if (div_zero_s || div_ovf_s) begin
                        result_d = special_s;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (mdu.flush) begin
                    count_d = {CW{1'b0}};
                    state_d = S_IDLE;
                end else if (count_q == CW'(WIDTH - 1)) begin
                    hi_d     = step_hi_s;
                    lo_d     = step_lo_s;
                    count_d  = {CW{1'b0}};
                    result_d = fin_s;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    hi_d    = step_hi_s;
                    lo_d    = step_lo_s;
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= {CW{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // A flush kills the stall in the same cycle so the pipeline can refetch.
    assign mdu.stall_out = ((state_q == S_IDLE) && mdu.start && !mdu.flush) ||
                           ((state_q == S_CALC) && !mdu.flush);
    assign mdu.result    = result_q;
    assign mdu.done      = done_q;
    assign mdu.busy      = busy_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases plus randomized
// operations scored against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
    localparam int W = 32;
    localparam int LAT_NORM = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] last_res = 32'd0;

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();
    ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mdu(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_NORM;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with start held until done; lat counts edges from issue to the done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit keep_start, output logic [31:0] res, output int lat,
                          output int stalls, output bit got);
        bus.funct3 = f; bus.operand1 = a; bus.operand2 = b;
        bus.start = 1'b1; bus.flush = 1'b0;
        lat = 0; stalls = 0; got = 1'b0; res = 32'd0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.stall_out) stalls++;
            if (bus.done) begin
                got = 1'b1;
                res = bus.result;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        @(posedge clk); #1;
        if (!keep_start) bus.start = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b);
        logic [31:0] res, exp;
        int lat, stalls, exp_lat;
        bit got;
        exp = ref_model(f, a, b);
        exp_lat = ref_latency(f, a, b);
        run_op(f, a, b, 1'b0, res, lat, stalls, got);
        n_cmp++;
        if (!got) begin
            n_fail++; $display("FAIL %s timeout: no done within budget", name);
        end else if (res !== exp) begin
            n_fail++; $display("FAIL %s result f=%0d a=%h b=%h got %h exp %h", name, f, a, b, res, exp);
        end
        n_cmp++;
        if (lat !== exp_lat || stalls !== exp_lat) begin
            n_fail++; $display("FAIL %s latency f=%0d got lat=%0d stall=%0d exp %0d", name, f, lat, stalls, exp_lat);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s post-done done=%b busy=%b exp 0/0", name, bus.done, bus.busy);
        end
        if (got) last_res = exp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
        bus.operand1 = 32'd0; bus.operand2 = 32'd0;
        rst = 1'b1;
        #2;
        n_cmp++;
        if (bus.result !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_state result=%h done=%b busy=%b stall=%b exp all 0",
                               bus.result, bus.done, bus.busy, bus.stall_out);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        check_op("mul_7_neg3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        n_cmp++;
        if (last_res !== 32'hFFFF_FFEB) begin
            n_fail++; $display("FAIL mul_7_neg3_const got %h exp FFFFFFEB", last_res);
        end
    endtask

    task automatic test_mul_high();
        check_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        check_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_rem();
        check_op("div_neg7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        check_op("rem_neg7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        check_op("divu_100_7", 3'd5, 32'd100, 32'd7);
        check_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    endtask

    task automatic test_special();
        check_op("div_by_zero", 3'd4, 32'd5, 32'd0);
        check_op("rem_by_zero", 3'd6, 32'd5, 32'd0);
        check_op("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("divu_by_zero", 3'd5, 32'd9, 32'd0);
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        bit seen_done;
        check_op("pre_flush", 3'd0, 32'd1234, 32'd5678);
        prev = last_res;
        seen_done = 1'b0;
        bus.funct3 = 3'd5; bus.operand1 = $urandom; bus.operand2 = $urandom | 32'd1;
        bus.start = 1'b1; bus.flush = 1'b0;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall stall_out=%b exp 0", bus.stall_out);
        end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle busy=%b exp 0", bus.busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_done !== 1'b0 || bus.result !== prev) begin
            n_fail++; $display("FAIL flush_nodone done_seen=%b result=%h exp 0/%h", seen_done, bus.result, prev);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] f;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            check_op("random", f, a, b);
        end
    endtask

    task automatic test_reset_mid();
        bus.funct3 = 3'd0; bus.operand1 = $urandom; bus.operand2 = $urandom;
        bus.start = 1'b1; bus.flush = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1; bus.start = 1'b0;
        #1;
        n_cmp++;
        if (bus.result !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid result=%h done=%b busy=%b stall=%b exp all 0",
                               bus.result, bus.done, bus.busy, bus.stall_out);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_res = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, r1, r2;
        int l1, l2, s1, s2;
        bit g1, g2;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        run_op(3'd0, a1, b1, 1'b1, r1, l1, s1, g1);
        run_op(3'd5, a2, b2, 1'b0, r2, l2, s2, g2);
        n_cmp++;
        if (!g1 || r1 !== ref_model(3'd0, a1, b1)) begin
            n_fail++; $display("FAIL b2b_mul got=%b res=%h exp %h", g1, r1, ref_model(3'd0, a1, b1));
        end
        n_cmp++;
        if (!g2 || r2 !== ref_model(3'd5, a2, b2) || l2 !== LAT_NORM) begin
            n_fail++; $display("FAIL b2b_divu got=%b res=%h lat=%0d exp %h lat %0d",
                               g2, r2, l2, ref_model(3'd5, a2, b2), LAT_NORM);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_div_rem();
        test_special();
        test_flush();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
